ntt_bank_ctrl: RTL and testbench
================================

# ntt_bank_ctrl

Address and control sequencer for the in-place radix-2 NTT engine. It drives two single-read/single-write data banks (bank0, bank1) and one twiddle ROM through all LOGN Cooley-Tukey stages, issuing one butterfly per cycle. Every butterfly pair lands in opposite banks, so the schedule never has a bank conflict. It also delays the write-back addresses to match the butterfly pipeline, and holds each stage until the previous stage's writes have completed.

## Interface
- LOGN, 10: log2 of transform size N; each bank holds N/2 words.
- AW, LOGN-1: bank address width (9 → 512-deep banks).
- BF_LAT, 4: butterfly latency in cycles, from bank Q valid to result valid at the bank D inputs.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a full transform; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until the done cycle, exclusive.
- done  out  1  one-cycle pulse when the last write has been committed.
- stage  out  4  current stage index 0..LOGN-1.
- en  out  1  bank EN; equals busy.
- ren  out  1  bank REN, common to both banks; high while reads are issued.
- rd_addr0  out  AW  bank0 read address (A2).
- rd_addr1  out  AW  bank1 read address (A2).
- tw_addr  out  LOGN  twiddle ROM address, issued in the same cycle as the reads.
- bf_valid  out  1  Q and twiddle are valid this cycle (ren delayed 1 cycle).
- bf_swap  out  1  when 1, the bank1 Q is the lower operand; aligned with bf_valid.
- wen  out  1  bank WEN, common to both banks; bf_valid delayed BF_LAT cycles.
- wr_addr0  out  AW  bank0 write address (A1), aligned with wen.
- wr_addr1  out  AW  bank1 write address (A1), aligned with wen.
- wr_swap  out  1  when 1, the lower result goes to bank1; aligned with wen.

## Operation
- **Address mapping.** Logical address a (LOGN bits) maps to bank = XOR of all bits of a, and bank address = a[LOGN-2:0].
- **Butterfly addresses.** In stage s, the distance is m = N>>(s+1) and the butterfly index k runs 0..N/2-1.
  - lo = k with a 0 bit inserted at bit position LOGN-1-s; hi = lo | m.
  - lo and hi differ in one bit, so they always sit in different banks.
- **Read routing.**
  - swap = parity(lo).
  - swap=0: rd_addr0 = lo bank address, rd_addr1 = hi bank address.
  - swap=1: rd_addr0 = hi bank address, rd_addr1 = lo bank address.
- **Twiddle address.** tw_addr = (1<<s) + (k >> (LOGN-1-s)). This is the bit-reversed twiddle ordering.
- **Write-back.** {rd_addr0, rd_addr1, swap} passes through a (1+BF_LAT)-stage shift register to become {wr_addr0, wr_addr1, wr_swap}. The write goes back in place to the same addresses.
- **FSM states.**
  - IDLE: start → RUN with s=0, k=0.
  - RUN: one read per cycle with ren=1. At k=N/2-1 → DRAIN.
  - DRAIN: ren=0 for exactly BF_LAT+1 cycles, so the last write of the stage is committed before the next stage's first read (no RAW hazard). Then, if s<LOGN-1: s++, k=0 → RUN; otherwise → DONE.
  - DONE: done=1 for one cycle → IDLE.
- **Pipeline flush.** The delay pipeline keeps shifting in every state, so all issued writes complete before DONE.
- **Reset.** rst in any state, including mid-transform:
  - FSM → IDLE, k=0, s=0.
  - The delay pipeline is cleared, so wen=0 on the next cycle and no partial stage completes.
  - Bank contents are undefined afterwards.
- **start while busy** is ignored. start in the DONE cycle is also ignored; a new transform can start from IDLE only.

## Timing
- **Reset values.** All outputs are 0: busy, done, stage, en, ren, rd_addr*, tw_addr, bf_valid, bf_swap, wen, wr_addr*, wr_swap.
- **Start latency.** start is sampled at edge E0. In the cycle after E0, busy=en=ren=1 and the k=0 read is presented.
- **Per-stage cycles.** A stage takes N/2 read cycles plus BF_LAT+1 drain cycles.
- **done** is high in cycle 1+LOGN·(N/2+BF_LAT+1) after E0, and busy is 0 in that same cycle.
- **Read-to-write alignment.** A read issued in cycle t gives bf_valid in cycle t+1 and wen with its addresses in cycle t+1+BF_LAT.
- **Counter width.** k is an AW-bit counter; no wrap beyond N/2-1 is reachable.

## Test plan
- **Reset/idle:** LOGN=3, BF_LAT=4, rst held 3 cycles → every output 0. No start → outputs stay 0.
- **Stage 0 addressing (LOGN=3):** start.
  - k=0: rd_addr0=0, rd_addr1=0, swap=0, tw_addr=1.
  - k=1: rd_addr0=1 (logical 5), rd_addr1=1 (logical 1), swap=1, tw_addr=1.
- **Stages 1/2 addressing:**
  - Stage 1, k=2: lo=4, hi=6, tw_addr=3.
  - Stage 2, k=3: lo=6, hi=7, tw_addr=7.
  - Check against a reference model every cycle: the banks are never equal within a pair, and every logical address is written exactly once per stage.
- **Latency and done:** LOGN=3, BF_LAT=4.
  - Reads in cycles 1–4, 10–13, 19–22.
  - wen in cycles 6–9, 15–18, 24–27.
  - done in cycle 28 only.
- **Mid-run reset and start-while-busy:**
  - rst in cycle 12 → from cycle 13 on, busy=0, wen=0, stage=0. A new start runs a full, correct sequence.
  - start pulses during busy do not alter the schedule.
- **Full-size functional:** LOGN=10, BF_LAT=4 with a bank model and a modular butterfly model, q=12289 (14-bit data).
  - Output matches the golden NTT.
  - done arrives in cycle 1+10·517 = 5171.

Source files
------------

// File: rtl/ntt_bank_ctrl_if.sv
// Bank/twiddle control bundle between the NTT address sequencer and the
// butterfly datapath (banks, twiddle ROM, butterfly pipeline).
interface ntt_bank_ctrl_if #(
    parameter int LOGN = 10,
    parameter int AW   = LOGN - 1
);
    logic            start;
    logic            busy;
    logic            done;
    logic [3:0]      stage;
    logic            en;
    logic            ren;
    logic [AW-1:0]   rd_addr0;
    logic [AW-1:0]   rd_addr1;
    logic [LOGN-1:0] tw_addr;
    logic            bf_valid;
    logic            bf_swap;
    logic            wen;
    logic [AW-1:0]   wr_addr0;
    logic [AW-1:0]   wr_addr1;
    logic            wr_swap;

    modport master (
        input  start,
        output busy, done, stage, en, ren, rd_addr0, rd_addr1, tw_addr,
               bf_valid, bf_swap, wen, wr_addr0, wr_addr1, wr_swap
    );

    modport slave (
        output start,
        input  busy, done, stage, en, ren, rd_addr0, rd_addr1, tw_addr,
               bf_valid, bf_swap, wen, wr_addr0, wr_addr1, wr_swap
    );
endinterface

// File: rtl/ntt_bank_ctrl.sv
// In-place radix-2 NTT address/control sequencer: one butterfly per cycle over
// two parity-interleaved banks, with write-back addresses delayed to match BF_LAT.
module ntt_bank_ctrl #(
    parameter int LOGN   = 10,
    parameter int AW     = LOGN - 1,
    parameter int BF_LAT = 4
) (
    input  logic           clk,
    input  logic           rst,
    ntt_bank_ctrl_if.master bus
);
    localparam int NH = 1 << AW;
    localparam int DW = $clog2(BF_LAT + 2);
    localparam logic [AW-1:0]   K_LAST = AW'(NH - 1);
    localparam logic [3:0]      S_LAST = 4'(LOGN - 1);
    localparam logic [DW-1:0]   D_LAST = DW'(BF_LAT);
    localparam logic [LOGN-1:0] ONE    = LOGN'(1);
    localparam logic [AW-1:0]   ONE_A  = AW'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic          sw;
    } wb_t;

    state_t          state, state_nx;
    logic [AW-1:0]   k, k_nx;
    logic [3:0]      s, s_nx;
    logic [DW-1:0]   dcnt, dcnt_nx;
    logic            ren;
    logic            done;

    logic [3:0]      p;
    logic [LOGN-1:0] kx, mask, lo, tw;
    logic [AW-1:0]   m_ba, hi_ba;
    logic            sw;
    wb_t             rd;
    logic [LOGN-1:0] tw_q;

    logic [BF_LAT+1:1] vld_pipe;
    wb_t  [BF_LAT+1:1] wb_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            s     <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            s     <= s_nx;
            dcnt  <= dcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        k_nx     = k;
        s_nx     = s;
        dcnt_nx  = dcnt;
        ren      = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = RUN;
                    k_nx     = '0;
                    s_nx     = '0;
                end
            end
            RUN: begin
                ren = 1'b1;
                if (k == K_LAST) begin
                    state_nx = DRAIN;
                    k_nx     = '0;
                    dcnt_nx  = '0;
                end else begin
                    k_nx = k + 1'b1;
                end
            end
            // BF_LAT+1 idle cycles so the last write lands before the next stage reads it
            DRAIN: begin
                if (dcnt == D_LAST) begin
                    dcnt_nx = '0;
                    if (s == S_LAST) begin
                        state_nx = DONE;
                        s_nx     = '0;
                    end else begin
                        state_nx = RUN;
                        s_nx     = s + 1'b1;
                    end
                end else begin
                    dcnt_nx = dcnt + 1'b1;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // lo = k with a zero inserted at bit p; hi differs only in bit p, so the
    // pair always has opposite parity and lands in opposite banks.
    always_comb begin
        p     = S_LAST - s;
        kx    = {1'b0, k};
        mask  = (ONE << p) - ONE;
        lo    = (((kx >> p) << p) << 1) | (kx & mask);
        m_ba  = ONE_A << p;
        hi_ba = lo[AW-1:0] | m_ba;
        sw    = ^lo;
        tw    = (ONE << s) + (kx >> p);
        rd    = '0;
        tw_q  = '0;
        if (ren) begin
            rd.sw = sw;
            rd.a0 = sw ? hi_ba : lo[AW-1:0];
            rd.a1 = sw ? lo[AW-1:0] : hi_ba;
            tw_q  = tw;
        end
    end

    // Keeps shifting in every state so issued writes always drain out.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            wb_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[BF_LAT:1], ren};
            wb_pipe  <= {wb_pipe[BF_LAT:1], rd};
        end
    end

    assign bus.busy     = (state == RUN) || (state == DRAIN);
    assign bus.en       = bus.busy;
    assign bus.done     = done;
    assign bus.stage    = s;
    assign bus.ren      = ren;
    assign bus.rd_addr0 = rd.a0;
    assign bus.rd_addr1 = rd.a1;
    assign bus.tw_addr  = tw_q;
    assign bus.bf_valid = vld_pipe[1];
    assign bus.bf_swap  = wb_pipe[1].sw;
    assign bus.wen      = vld_pipe[BF_LAT+1];
    assign bus.wr_addr0 = wb_pipe[BF_LAT+1].a0;
    assign bus.wr_addr1 = wb_pipe[BF_LAT+1].a1;
    assign bus.wr_swap  = wb_pipe[BF_LAT+1].sw;
endmodule

// File: tb/tb_ntt_bank_ctrl.sv
// Directed bench for ntt_bank_ctrl: LOGN=3 schedule/latency/reset cases and a
// LOGN=10 full run, checked cycle by cycle against a timing/address model.
module tb_ntt_bank_ctrl;
    localparam int BL = 4;

    logic clk;
    logic rst3, rst10;
    int   ncmp, nerr;

    ntt_bank_ctrl_if #(.LOGN(3))  if3 ();
    ntt_bank_ctrl_if #(.LOGN(10)) if10 ();

    ntt_bank_ctrl #(.LOGN(3),  .BF_LAT(BL)) dut3  (.clk(clk), .rst(rst3),  .bus(if3));
    ntt_bank_ctrl #(.LOGN(10), .BF_LAT(BL)) dut10 (.clk(clk), .rst(rst10), .bus(if10));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] busy, en, done, stage, ren, rd0, rd1, tw;
        logic [31:0] bfv, bfs, wen, wa0, wa1, wsw;
    } obs_t;

    typedef struct packed {
        logic [31:0] ok, sw, a0, a1, tw;
    } rd_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic int par(input int v);
        int r = 0;
        for (int i = 0; i < 16; i++) r ^= (v >> i) & 1;
        return r;
    endfunction

    // Read issued in cycle c after the start edge (c=1 is the first read).
    function automatic rd_t rdinfo(input int logn, input int c);
        rd_t r = '0;
        int n2  = 1 << (logn - 1);
        int per = n2 + BL + 1;
        int k, st, m, lo, hi;
        if (c < 1 || c > logn * per) return r;
        k  = (c - 1) % per;
        st = (c - 1) / per;
        if (k >= n2) return r;
        m  = n2 >> st;
        lo = (k / m) * 2 * m + (k % m);
        hi = lo + m;
        r.ok = 1;
        r.sw = par(lo);
        r.a0 = (r.sw != 0 ? hi : lo) % n2;
        r.a1 = (r.sw != 0 ? lo : hi) % n2;
        r.tw = (1 << st) + k / m;
        return r;
    endfunction

    function automatic obs_t model(input int logn, input int c);
        obs_t e = '0;
        rd_t  r, v, w;
        int per  = (1 << (logn - 1)) + BL + 1;
        int last = logn * per + 1;
        r = rdinfo(logn, c);
        v = rdinfo(logn, c - 1);
        w = rdinfo(logn, c - 1 - BL);
        e.busy  = (c >= 1 && c < last) ? 1 : 0;
        e.en    = e.busy;
        e.done  = (c == last) ? 1 : 0;
        e.stage = (e.busy != 0) ? (c - 1) / per : 0;
        e.ren = r.ok; e.rd0 = r.a0; e.rd1 = r.a1; e.tw = r.tw;
        e.bfv = v.ok; e.bfs = v.sw;
        e.wen = w.ok; e.wa0 = w.a0; e.wa1 = w.a1; e.wsw = w.sw;
        return e;
    endfunction

    function automatic obs_t sample(input int logn);
        obs_t o = '0;
        if (logn == 3) begin
            o.busy = 32'(if3.busy);  o.en = 32'(if3.en);   o.done = 32'(if3.done);
            o.stage = 32'(if3.stage); o.ren = 32'(if3.ren);
            o.rd0 = 32'(if3.rd_addr0); o.rd1 = 32'(if3.rd_addr1); o.tw = 32'(if3.tw_addr);
            o.bfv = 32'(if3.bf_valid); o.bfs = 32'(if3.bf_swap); o.wen = 32'(if3.wen);
            o.wa0 = 32'(if3.wr_addr0); o.wa1 = 32'(if3.wr_addr1); o.wsw = 32'(if3.wr_swap);
        end else begin
            o.busy = 32'(if10.busy);  o.en = 32'(if10.en);   o.done = 32'(if10.done);
            o.stage = 32'(if10.stage); o.ren = 32'(if10.ren);
            o.rd0 = 32'(if10.rd_addr0); o.rd1 = 32'(if10.rd_addr1); o.tw = 32'(if10.tw_addr);
            o.bfv = 32'(if10.bf_valid); o.bfs = 32'(if10.bf_swap); o.wen = 32'(if10.wen);
            o.wa0 = 32'(if10.wr_addr0); o.wa1 = 32'(if10.wr_addr1); o.wsw = 32'(if10.wr_swap);
        end
        return o;
    endfunction

    task automatic cmp(input obs_t o, input obs_t e, input string t);
        chk({t, "busy"},  o.busy,  e.busy);
        chk({t, "en"},    o.en,    e.busy);
        chk({t, "done"},  o.done,  e.done);
        chk({t, "stage"}, o.stage, e.stage);
        chk({t, "ren"},   o.ren,   e.ren);
        chk({t, "bf_valid"}, o.bfv, e.bfv);
        chk({t, "wen"},   o.wen,   e.wen);
        if (e.ren != 0 || e.busy == 0) begin
            chk({t, "rd_addr0"}, o.rd0, e.rd0);
            chk({t, "rd_addr1"}, o.rd1, e.rd1);
            chk({t, "tw_addr"},  o.tw,  e.tw);
        end
        if (e.bfv != 0 || e.busy == 0) chk({t, "bf_swap"}, o.bfs, e.bfs);
        if (e.wen != 0 || e.busy == 0) begin
            chk({t, "wr_addr0"}, o.wa0, e.wa0);
            chk({t, "wr_addr1"}, o.wa1, e.wa1);
            chk({t, "wr_swap"},  o.wsw, e.wsw);
        end
    endtask

    task automatic set_start(input int logn, input logic v);
        if (logn == 3) if3.start = v;
        else           if10.start = v;
    endtask

    // Bank b, bank address x -> logical address whose parity selects bank b.
    function automatic int logical(input int logn, input int b, input int x);
        return ((b ^ par(x)) << (logn - 1)) | x;
    endfunction

    task automatic run(input int logn, input int rst_at, input bit pokes);
        int   n2   = 1 << (logn - 1);
        int   per  = n2 + BL + 1;
        int   last = logn * per + 1;
        int   lim  = (rst_at >= 0) ? rst_at + 2 : last + 3;
        int   cnt[1024];
        int   bad;
        obs_t o, e;
        string t;
        for (int i = 0; i < 1024; i++) cnt[i] = 0;
        set_start(logn, 1'b1);
        @(negedge clk);
        set_start(logn, 1'b0);
        for (int c = 1; c <= lim; c++) begin
            t = $sformatf("n%0d c%0d ", logn, c);
            o = sample(logn);
            e = (rst_at >= 0 && c > rst_at) ? obs_t'('0) : model(logn, c);
            cmp(o, e, t);
            if (rst_at < 0 || c <= rst_at) begin
                if (o.wen != 0) begin
                    cnt[logical(logn, 0, int'(o.wa0))]++;
                    cnt[logical(logn, 1, int'(o.wa1))]++;
                end
                if (c % per == 0 && c / per >= 1 && c / per <= logn) begin
                    bad = 0;
                    for (int i = 0; i < 2 * n2; i++) begin
                        if (cnt[i] != 1) bad++;
                        cnt[i] = 0;
                    end
                    chk({t, "write_once"}, bad, 0);
                end
            end
            if (logn == 3 && rst_at < 0) begin
                if (c == 1)  begin chk("s0k0 rd0", o.rd0, 0); chk("s0k0 rd1", o.rd1, 0); chk("s0k0 tw", o.tw, 1); end
                if (c == 2)  begin chk("s0k1 rd0", o.rd0, 1); chk("s0k1 rd1", o.rd1, 1); chk("s0k1 tw", o.tw, 1); end
                if (c == 3)  chk("s0k1 swap", o.bfs, 1);
                if (c == 12) begin chk("s1k2 rd0", o.rd0, 2); chk("s1k2 rd1", o.rd1, 0); chk("s1k2 tw", o.tw, 3); end
                if (c == 22) begin chk("s2k3 rd0", o.rd0, 2); chk("s2k3 rd1", o.rd1, 3); chk("s2k3 tw", o.tw, 7); end
                if (c == 28) chk("done28", o.done, 1);
            end
            if (logn == 10 && c == 5171) chk("done5171", o.done, 1);
            set_start(logn, pokes && (c == 5 || c == 15 || c == last));
            if (rst_at >= 0 && c == rst_at)     rst3 = 1'b1;
            if (rst_at >= 0 && c == rst_at + 1) rst3 = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        rst3 = 1'b1;
        rst10 = 1'b1;
        if3.start = 1'b0;
        if10.start = 1'b0;
        repeat (3) @(negedge clk);
        cmp(sample(3),  obs_t'('0), "rst3 ");
        cmp(sample(10), obs_t'('0), "rst10 ");
        rst3 = 1'b0;
        rst10 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmp(sample(3),  obs_t'('0), "idle3 ");
            cmp(sample(10), obs_t'('0), "idle10 ");
        end
        run(3, -1, 1'b0);
        run(3, 12, 1'b0);
        run(3, -1, 1'b1);
        run(10, -1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
